// File: rtl/calc_engine_pkg.sv
// Shared definitions for the matrix calculation engine: default sizes, op codes,
// FSM state encoding and a dimension range helper.
package calc_engine_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int RES_W   = 20;
  localparam int ADDR_W  = 5;
  localparam int DIM_W   = 3;
  localparam int OP_W    = 4;

  typedef enum logic [OP_W-1:0] {
    OP_TRANSPOSE = 4'd0,
    OP_ADD       = 4'd1,
    OP_SCALE     = 4'd2,
    OP_MATMUL    = 4'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACC,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
    return (d != '0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/calc_legal_check.sv
// Combinational operand legality: dimension ranges and shape compatibility per op.
module calc_legal_check
  import calc_engine_pkg::*;
#(
  parameter int MAX_D = calc_engine_pkg::MAX_DIM
) (
  input  logic [OP_W-1:0]  op_type,
  input  logic [DIM_W-1:0] a_m,
  input  logic [DIM_W-1:0] a_n,
  input  logic [DIM_W-1:0] b_m,
  input  logic [DIM_W-1:0] b_n,
  output logic             legal
);

  logic a_ok;
  logic b_ok;

  assign a_ok = dim_ok(a_m, MAX_D) && dim_ok(a_n, MAX_D);
  assign b_ok = dim_ok(b_m, MAX_D) && dim_ok(b_n, MAX_D);

  // Transpose and scalar multiply never look at B, so its dims are don't-care.
  always_comb begin
    legal = 1'b0;
    case (op_type)
      OP_TRANSPOSE, OP_SCALE: legal = a_ok;
      OP_ADD:                 legal = a_ok && b_ok && (a_m == b_m) && (a_n == b_n);
      OP_MATMUL:              legal = a_ok && b_ok && (a_n == b_m);
      default:                legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_engine.sv
// Sequential matrix engine: transpose, add, scalar multiply and matrix multiply
// over row-major operand memories with a 1-cycle read latency.
module calc_engine
  import calc_engine_pkg::*;
#(
  parameter int MAX_DIM = calc_engine_pkg::MAX_DIM,
  parameter int ELEM_W  = calc_engine_pkg::ELEM_W,
  parameter int RES_W   = calc_engine_pkg::RES_W,
  parameter int ADDR_W  = calc_engine_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [OP_W-1:0]          op_type,
  input  logic [DIM_W-1:0]         a_m,
  input  logic [DIM_W-1:0]         a_n,
  input  logic [DIM_W-1:0]         b_m,
  input  logic [DIM_W-1:0]         b_n,
  input  logic signed [ELEM_W-1:0] scalar,
  output logic                     operand_legal,
  output logic [ADDR_W-1:0]        a_rd_addr,
  output logic [ADDR_W-1:0]        b_rd_addr,
  input  logic signed [ELEM_W-1:0] a_rd_data,
  input  logic signed [ELEM_W-1:0] b_rd_data,
  output logic                     res_wr_en,
  output logic [ADDR_W-1:0]        res_wr_addr,
  output logic signed [RES_W-1:0]  res_wr_data,
  output logic [DIM_W-1:0]         res_m,
  output logic [DIM_W-1:0]         res_n,
  output logic                     busy,
  output logic                     compute_done,
  output logic                     op_error
);

  state_e                    state;
  op_e                       op_q;
  logic [DIM_W-1:0]          a_n_q;
  logic [DIM_W-1:0]          b_n_q;
  logic signed [ELEM_W-1:0]  scalar_q;
  logic [DIM_W-1:0]          i;
  logic [DIM_W-1:0]          j;
  logic [DIM_W-1:0]          k;
  logic signed [RES_W-1:0]   acc;

  logic signed [RES_W-1:0]   a_ext;
  logic signed [RES_W-1:0]   b_ext;
  logic signed [RES_W-1:0]   s_ext;
  logic signed [RES_W-1:0]   term;
  logic signed [RES_W-1:0]   acc_next;
  logic                      j_wrap;
  logic                      last_elem;
  logic [DIM_W-1:0]          i_next;
  logic [DIM_W-1:0]          j_next;

  calc_legal_check #(.MAX_D(MAX_DIM)) u_legal (
    .op_type (op_type),
    .a_m     (a_m),
    .a_n     (a_n),
    .b_m     (b_m),
    .b_n     (b_n),
    .legal   (operand_legal)
  );

  function automatic logic [ADDR_W-1:0] lin(input logic [DIM_W-1:0] r,
                                            input logic [DIM_W-1:0] cols,
                                            input logic [DIM_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(cols) + ADDR_W'(c);
  endfunction

  function automatic logic [ADDR_W-1:0] a_addr(input op_e op, input logic [DIM_W-1:0] ri,
                                               input logic [DIM_W-1:0] rj, input logic [DIM_W-1:0] rk);
    case (op)
      OP_TRANSPOSE: return lin(rj, a_n_q, ri);
      OP_MATMUL:    return lin(ri, a_n_q, rk);
      default:      return lin(ri, a_n_q, rj);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] b_addr(input op_e op, input logic [DIM_W-1:0] ri,
                                               input logic [DIM_W-1:0] rj, input logic [DIM_W-1:0] rk);
    case (op)
      OP_ADD:    return lin(ri, b_n_q, rj);
      OP_MATMUL: return lin(rk, b_n_q, rj);
      default:   return '0;
    endcase
  endfunction

  assign a_ext = {{(RES_W-ELEM_W){a_rd_data[ELEM_W-1]}}, a_rd_data};
  assign b_ext = {{(RES_W-ELEM_W){b_rd_data[ELEM_W-1]}}, b_rd_data};
  assign s_ext = {{(RES_W-ELEM_W){scalar_q[ELEM_W-1]}}, scalar_q};

  always_comb begin
    term = '0;
    case (op_q)
      OP_TRANSPOSE: term = a_ext;
      OP_ADD:       term = a_ext + b_ext;
      OP_SCALE:     term = s_ext * a_ext;
      OP_MATMUL:    term = a_ext * b_ext;
      default:      term = '0;
    endcase
  end

  assign acc_next  = acc + term;
  assign j_wrap    = (j == res_n - 3'd1);
  assign last_elem = j_wrap && (i == res_m - 3'd1);
  assign i_next    = j_wrap ? i + 3'd1 : i;
  assign j_next    = j_wrap ? '0 : j + 3'd1;
  assign busy      = (state != ST_IDLE);

  // The first element of every op reads address 0, so leaving IDLE needs no address update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_TRANSPOSE;
      a_n_q        <= '0;
      b_n_q        <= '0;
      scalar_q     <= '0;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      acc          <= '0;
      a_rd_addr    <= '0;
      b_rd_addr    <= '0;
      res_wr_en    <= 1'b0;
      res_wr_addr  <= '0;
      res_wr_data  <= '0;
      res_m        <= '0;
      res_n        <= '0;
      compute_done <= 1'b0;
      op_error     <= 1'b0;
    end else begin
      res_wr_en    <= 1'b0;
      compute_done <= 1'b0;
      op_error     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && operand_legal) begin
            op_q     <= op_e'(op_type);
            a_n_q    <= a_n;
            b_n_q    <= b_n;
            scalar_q <= scalar;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            case (op_type)
              OP_TRANSPOSE: begin res_m <= a_n; res_n <= a_m; end
              OP_MATMUL:    begin res_m <= a_m; res_n <= b_n; end
              default:      begin res_m <= a_m; res_n <= a_n; end
            endcase
            state <= ST_ISSUE;
          end else if (start) begin
            op_error <= 1'b1;
            state    <= ST_ERR;
          end
        end
        ST_ISSUE: begin
          a_rd_addr <= '0;
          b_rd_addr <= '0;
          state     <= ST_ACC;
        end
        ST_ACC: begin
          acc <= acc_next;
          if (op_q == OP_MATMUL && k != a_n_q - 3'd1) begin
            k         <= k + 3'd1;
            a_rd_addr <= a_addr(op_q, i, j, k + 3'd1);
            b_rd_addr <= b_addr(op_q, i, j, k + 3'd1);
            state     <= ST_ISSUE;
          end else begin
            res_wr_en   <= 1'b1;
            res_wr_addr <= lin(i, res_n, j);
            res_wr_data <= acc_next;
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          acc <= '0;
          k   <= '0;
          if (last_elem) begin
            compute_done <= 1'b1;
            state        <= ST_DONE;
          end else begin
            i         <= i_next;
            j         <= j_next;
            a_rd_addr <= a_addr(op_q, i_next, j_next, 3'd0);
            b_rd_addr <= b_addr(op_q, i_next, j_next, 3'd0);
            state     <= ST_ISSUE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameters (name, default, meaning): MAX_DIM 5 max rows/cols; ELEM_W 8 signed operand element width; RES_W 20 signed result width; ADDR_W 5 element address width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 start  in  1  one-cycle request pulse from the mode controller.
REQ-006 op_type  in  4  0 transpose, 1 add, 2 scalar multiply, 3 matrix multiply; other codes illegal.
REQ-007 a_m, a_n, b_m, b_n  in  3 each  operand A/B rows, cols.
REQ-008 scalar  in  ELEM_W  signed scalar for op 2.
REQ-009 operand_legal  out  1  combinational legality of current inputs.
REQ-010 a_rd_addr, b_rd_addr  out  ADDR_W  operand read addresses.
REQ-011 a_rd_data, b_rd_data  in  ELEM_W  read data, valid exactly 1 cycle after address.
REQ-012 res_wr_en  out  1; res_wr_addr  out  ADDR_W; res_wr_data  out  RES_W  result write port.
REQ-013 res_m, res_n  out  3  result dimensions, valid from DONE until next start.
REQ-014 busy  out 1; compute_done  out 1 (pulse); op_error  out 1 (pulse).

Function
REQ-015 Legal: all dims in 1..MAX_DIM used by op; op 1 needs a_m==b_m and a_n==b_n; op 3 needs a_n==b_m; ops 0,2 ignore B dims.
REQ-016 States: IDLE, ISSUE, ACC, WRITE, DONE, ERR.
REQ-017 IDLE: start && legal -> latch op, dims, scalar; clear i,j,k,acc; -> ISSUE. start && !legal -> ERR.
REQ-018 start when not IDLE is ignored; latched inputs do not change mid-operation.
REQ-019 ISSUE: drive addresses for current (i,j,k); -> ACC.
REQ-020 ACC: acc += term(rd_data); op 3 with k<a_n-1 -> k++, ISSUE; else -> WRITE.
REQ-021 WRITE: res_wr_en=1 for one cycle, addr i*res_n+j, data acc; clear acc,k; advance j then i; last element -> DONE else ISSUE.
REQ-022 DONE: compute_done=1 one cycle; -> IDLE. ERR: op_error=1 one cycle, no writes; -> IDLE.
REQ-023 Addressing row-major compact: element (r,c) of matrix with C cols at r*C+c.
REQ-024 Op 0: res dims a_n x a_m; (i,j) reads A addr j*a_n+i.
REQ-025 Op 1: (i,j) = A[i][j]+B[i][j]; op 2: scalar*A[i][j]; op 3: sum over k A[i][k]*B[k][j], res a_m x b_n.
REQ-026 Arithmetic signed, sign-extended to RES_W; no overflow possible at defaults, none detected.
REQ-027 Latency: ops 0-2 three cycles per element; op 3 2*a_n+1 per element; DONE follows last WRITE; 1x1 op 1 start -> compute_done at cycle 4.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Addresses held 0 and res_wr_en 0 outside ISSUE/WRITE respectively.

Reset
REQ-030 rst_n low: state IDLE; all counters, acc, latched regs 0; res_wr_en, compute_done, op_error, busy 0; addresses, res_m, res_n 0.
REQ-031 Reset mid-operation aborts immediately; no further writes; no compute_done.

Structure
REQ-032 Shared package: op codes, MAX_DIM, ELEM_W, RES_W, ADDR_W, state encoding.
REQ-033 One sub-module: calc_legal_check (combinational legality, used for operand_legal and start gating).

Verification
REQ-034 op1, A=B=1x1 {5}/{-3}, start -> one write addr0 data 2, compute_done 3 cycles after ISSUE entry, busy low after.
REQ-035 op3, A 2x3 {1,2,3,4,5,6}, B 3x2 {7,8,9,10,11,12} -> writes 58,64,139,154 at addr 0..3, res 2x2, 7 cycles per element.
REQ-036 op0, A 2x3 {1..6} -> writes 1,4,2,5,3,6, res 3x2.
REQ-037 op3, a_n=3, b_m=2 -> operand_legal 0, op_error pulse, no res_wr_en, no compute_done.
REQ-038 op2 scalar -128, A 5x5 all -128 -> 25 writes of 16384; second start mid-run ignored.
REQ-039 rst_n low during op3 WRITE phase -> res_wr_en 0 same cycle, busy 0, no compute_done after release.
